// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Three-port arbiter for a single block-RAM port. Round-robin with
//            display-urgent override, starvation guard and a read-return tag
//            pipeline matched to the RAM read latency. Optional write protect
//            of the upper address range when MEM_ARB_WP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int                ADDR_W     = 15,
    parameter int                DATA_W     = 16,
    parameter int                RD_LAT     = 1,
    parameter int                STARVE_MAX = 8,
    parameter logic [ADDR_W-1:0] WP_BASE    = 15'h2400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              req2,
    input  logic              we0,
    input  logic              we1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    input  logic              disp_urgent,
    output logic              gnt0,
    output logic              gnt1,
    output logic              gnt2,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              rvalid2,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wp_err
);

    localparam int                 c_CNT_W  = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE = c_CNT_W'(STARVE_MAX);

    logic [2:0]        w_req;
    logic [2:0]        w_we;
    logic [ADDR_W-1:0] w_addr  [3];
    logic [DATA_W-1:0] w_wdata [3];

    logic              w_win_vld;
    logic              w_rr_win;
    logic [1:0]        w_win;
    logic [2:0]        w_gnt;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_we;
    logic              w_wp_hit;
    logic              w_out_vld;
    logic [1:0]        w_out_port;

    logic [1:0]         r_ptr;
    logic [c_CNT_W-1:0] r_cnt [3];
    logic [ADDR_W-1:0]  r_last_addr;
    logic [DATA_W-1:0]  r_last_wdata;
    logic [RD_LAT-1:0]  r_tag_vld;
    logic [1:0]         r_tag_port [RD_LAT];

    assign w_req      = {req2, req1, req0};
    assign w_we       = {we2, we1, we0};
    assign w_addr[0]  = addr0;
    assign w_addr[1]  = addr1;
    assign w_addr[2]  = addr2;
    assign w_wdata[0] = wdata0;
    assign w_wdata[1] = wdata1;
    assign w_wdata[2] = wdata2;

    // Priority: starved port (lowest index) > urgent display > round-robin.
    always_comb begin
        w_win_vld = 1'b0;
        w_rr_win  = 1'b0;
        w_win     = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (w_req[i] && (r_cnt[i] == c_STARVE)) begin
                w_win_vld = 1'b1;
                w_win     = 2'(i);
            end
        end
        if (!w_win_vld && w_req[0] && disp_urgent) begin
            w_win_vld = 1'b1;
            w_win     = 2'd0;
        end
        if (!w_win_vld) begin
            // Walk backwards so the first requester after the pointer sticks.
            for (int k = 3; k >= 1; k--) begin
                if (w_req[(int'(r_ptr) + k) % 3]) begin
                    w_win_vld = 1'b1;
                    w_rr_win  = 1'b1;
                    w_win     = 2'((int'(r_ptr) + k) % 3);
                end
            end
        end
        if (reset) begin
            w_win_vld = 1'b0;
            w_rr_win  = 1'b0;
        end
    end

    assign w_gnt       = w_win_vld ? (3'b001 << w_win) : 3'b000;
    assign w_sel_addr  = w_addr[w_win];
    assign w_sel_wdata = w_wdata[w_win];
    assign w_sel_we    = w_we[w_win];

`ifdef MEM_ARB_WP_EN
    assign w_wp_hit = w_win_vld && (w_win != 2'd0) && w_sel_we && (w_sel_addr >= WP_BASE);
`else
    logic w_unused_wp_base;
    assign w_unused_wp_base = ^WP_BASE;
    assign w_wp_hit         = 1'b0;
`endif

    assign gnt0      = w_gnt[0];
    assign gnt1      = w_gnt[1];
    assign gnt2      = w_gnt[2];
    assign mem_we    = w_win_vld && w_sel_we && !w_wp_hit;
    assign mem_addr  = reset ? '0 : (w_win_vld ? w_sel_addr : r_last_addr);
    assign mem_wdata = reset ? '0 : (w_win_vld ? w_sel_wdata : r_last_wdata);
    assign wp_err    = w_wp_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= 2'd2;
            r_last_addr  <= '0;
            r_last_wdata <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (w_rr_win) begin
                r_ptr <= w_win;
            end
            if (w_win_vld) begin
                r_last_addr  <= w_sel_addr;
                r_last_wdata <= w_sel_wdata;
            end
            for (int i = 0; i < 3; i++) begin
                if (!w_req[i] || w_gnt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] != c_STARVE) begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_W'(1);
                end
            end
        end
    end

    // Read tags travel alongside the RAM pipeline; writes insert bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_port[i] <= 2'd0;
            end
        end else begin
            r_tag_vld[0]  <= w_win_vld && !w_sel_we;
            r_tag_port[0] <= w_win;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_port[i] <= r_tag_port[i-1];
            end
        end
    end

    assign w_out_vld  = r_tag_vld[RD_LAT-1] && !reset;
    assign w_out_port = r_tag_port[RD_LAT-1];
    assign rvalid0    = w_out_vld && (w_out_port == 2'd0);
    assign rvalid1    = w_out_vld && (w_out_port == 2'd1);
    assign rvalid2    = w_out_vld && (w_out_port == 2'd2);
    assign rdata      = w_out_vld ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 16-bit block-RAM port (15-bit word address) between three requesters:
  - port 0: display fetch
  - port 1: CPU core
  - port 2: I/O / loader
- Sits between the requesters and the RAM primitive.
- Round-robin arbitration, with an urgent override for display and a starvation guard.
- Read data comes back through a per-port valid pipeline that matches the fixed RAM read latency.

Parameters:
- ADDR_W, 15, word address width.
- DATA_W, 16, data width.
- RD_LAT, 1, RAM read latency in cycles; legal values 1..3.
- STARVE_MAX, 8, wait cycles after which a pending port is forced to win.
- WP_BASE, 15'h2400, lowest write-protected address (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req0/req1/req2  in  1 each  access request; held until granted.
- we0/we1/we2  in  1 each  1 = write, 0 = read.
- addr0/addr1/addr2  in  ADDR_W each  word address.
- wdata0/wdata1/wdata2  in  DATA_W each  write data.
- disp_urgent  in  1  display FIFO low; port 0 takes priority.
- gnt0/gnt1/gnt2  out  1 each  one-cycle pulse: request accepted this cycle.
- rvalid0/rvalid1/rvalid2  out  1 each  read data valid for that port.
- rdata  out  DATA_W  shared read-return bus.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.
- wp_err  out  1  protected-write pulse (optional feature only; constant 0 otherwise).

Behaviour:
- Reset values:
  - all gnt, rvalid and mem_we = 0; wp_err = 0.
  - mem_addr = 0, mem_wdata = 0, rdata = 0.
  - last-grant pointer = 2, so port 0 is first in RR order.
  - starvation counters = 0; read-tag pipeline cleared.
- Reset mid-operation: in-flight reads are discarded and no rvalid is issued for them.
- Issue:
  - At most one transaction per cycle.
  - Winner chosen combinationally in cycle t from the req inputs.
  - In cycle t: gntW = 1, and mem_addr / mem_we / mem_wdata are driven combinationally from the winner's inputs.
  - No request pending: mem_we = 0 and mem_addr holds its last value.
- Winner selection, highest priority first:
  - (a) Any port whose starvation counter = STARVE_MAX. If several, lowest index wins.
  - (b) Port 0 if req0 and disp_urgent.
  - (c) Round-robin: first requesting port after the last-grant pointer, modulo 3.
- Pointer update: the last-grant pointer takes the winner's index only for RR wins (c). Wins under (a) and (b) leave it unchanged.
- Starvation counter, per port:
  - Increments (saturating at STARVE_MAX) each cycle the port has req high and no gnt.
  - Clears on its gnt.
  - Clears when req drops.
- Read return:
  - Granted reads push a tag {valid, port} into an RD_LAT-deep shift register.
  - Tag exits in cycle t+RD_LAT: rvalid of the tagged port = 1 for one cycle, and rdata = mem_rdata in that same cycle (combinational pass-through).
  - Back-to-back reads give back-to-back rvalids in issue order.
  - Writes push no tag.
- Requester protocol: the arbiter samples req/addr/we/wdata only in the cycle gnt is high. A requester may drop req without being granted; no side effect.
- Simultaneous events: a read return for one port and a new grant to the same or another port in the same cycle are both legal and independent.

Optional Feature:
- Macro MEM_ARB_WP_EN.
- Defined:
  - A write from port 1 or 2 with addr >= WP_BASE is still granted (gnt pulses).
  - mem_we is forced to 0 for that write.
  - wp_err pulses 1 in the same cycle.
  - Port 0 is never write-checked.
- Undefined: no address check; wp_err is tied to 0.

Test Plan:
- Reset, then req1 read addr 15'h2400 alone, RAM word = 16'h1234 (RD_LAT=1) -> gnt1 in cycle t; rvalid1 = 1 with rdata = 16'h1234 at t+1; mem_we = 0.
- req0, req1 and req2 all held continuously, disp_urgent = 0 -> grant order 0,1,2,0,1,2; each gnt is a single pulse.
- req1 and req2 held, req0 with disp_urgent = 1 for 10 cycles -> port 0 wins every cycle until port 1 counter hits STARVE_MAX = 8 (gnt1 at cycle 9); port 2 granted next once its counter is at max.
- RD_LAT = 3: port 2 read addr 5 then port 1 read addr 6 on consecutive cycles -> rvalid2 at t+3 with word[5], rvalid1 at t+4 with word[6].
- Read granted at t, reset asserted at t+1 (RD_LAT = 2) -> no rvalid at t+2; all outputs at reset values.
- MEM_ARB_WP_EN defined: port 1 write addr 15'h2500, data 16'hBEEF -> gnt1 = 1, mem_we = 0, wp_err pulse, RAM unchanged. Port 0 write to the same address -> mem_we = 1, no wp_err.
